rr_bus_arbiter: RTL and testbench
=================================

# rr_bus_arbiter

Round-robin arbiter that shares one downstream port among `NUM_REQ` requesters. It sequences the shared datapath multiplexer: it owns the select line, forwards the winning requester's data and valid, and returns per-requester beat acknowledgements. Ownership is burst-granular, so a requester keeps the port from its first accepted beat through its `i_last` beat. It sits between multiple bus masters (fetch, load/store, debug) and a single memory or peripheral port.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be at least 2.
- `DATA_WIDTH`, default 32: payload width per requester.
- `SELECT_BITS`, derived as `$clog2(NUM_REQ)`: width of the select and owner index.

- `i_clk`, input, 1: single clock; all state updates on its rising edge.
- `i_rst_n`, input, 1: reset, asynchronous and active-low.
- `i_req`, input, `NUM_REQ`: per-requester valid/request, bit k belongs to requester k.
- `i_last`, input, `NUM_REQ`: bit k marks requester k's current beat as the final beat of its burst.
- `i_data_bus`, input, `NUM_REQ*DATA_WIDTH`: packed payloads; requester k occupies `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `i_ready`, input, 1: downstream accepts the presented beat this cycle.
- `o_valid`, output, 1: beat presented downstream.
- `o_data`, output, `DATA_WIDTH`: payload of the current owner.
- `o_select`, output, `SELECT_BITS`: index of the current owner; drives the shared mux.
- `o_gnt`, output, `NUM_REQ`: one-hot beat-accept acknowledgement to the owner.
- `o_busy`, output, 1: a burst is in progress (state is BUSY).

## Operation
- The FSM has two states, IDLE and BUSY. The registered state is: state, `owner` (`SELECT_BITS`), and `ptr` (`SELECT_BITS`, the round-robin start point).
- **IDLE:**
  - If `i_req` is nonzero, scan indices `ptr`, `ptr+1`, and so on, modulo `NUM_REQ`; the first set bit wins.
  - At the clock edge, `owner` takes the winner and the state goes to BUSY.
  - If `i_req` is zero, the block stays in IDLE.
  - Outputs in IDLE: `o_valid=0`, `o_gnt=0`, `o_data=0`, and `o_select=owner` (held).
- **BUSY:**
  - `o_select=owner`.
  - `o_valid=i_req[owner]`.
  - `o_data` is the owner's slice when `o_valid` is 1, else 0.
  - `o_gnt[owner]=i_req[owner] & i_ready`; all other bits are 0.
- **Beat accepted** (`o_valid & i_ready`) with `i_last[owner]=1`: the state goes to IDLE and `ptr` becomes `owner+1`, wrapping `NUM_REQ-1` to 0.
- **Abort:** `i_req[owner]=0` in BUSY is an abort. The state goes to IDLE and `ptr` becomes `owner+1`. No beat is acknowledged.
- `i_last` is ignored unless a beat is accepted.
- Requests from non-owners while BUSY are ignored and never acknowledged. Requesters hold `i_req` until acknowledged.
- `i_ready` while `o_valid=0` has no effect.
- `o_gnt` is combinational from the inputs and registered state. `o_busy` and `o_select` depend on registered state only.

## Timing
- **Reset** (asynchronous assert, synchronous to `i_clk` on release): state IDLE, `owner=0`, `ptr=0`.
  - Outputs during reset: `o_valid=0`, `o_gnt=0`, `o_data=0`, `o_select=0`, `o_busy=0`.
- **Reset mid-burst:** the burst is dropped immediately, with no further `o_gnt`.
- **Arbitration latency:** a request sampled in IDLE in cycle N gives `o_valid` in cycle N+1 at the earliest.
- **Bubble:** each burst end or abort forces at least one IDLE cycle before the next burst. Peak throughput is `L/(L+1)` for bursts of L beats.
- **Single-beat burst:** one BUSY cycle when `i_ready=1`.
- **Stalls:** `i_ready=0` holds BUSY indefinitely. There is no timeout.
- **Fairness:** with all requesters asserting continuously, grants rotate 0,1,2,…,`NUM_REQ-1`,0. No requester waits more than `NUM_REQ-1` bursts.
- **Same-cycle events:** last-beat accept and new requests in the same cycle cause no arbitration in that cycle. The next IDLE cycle arbitrates from the updated `ptr`.

## Test plan
- **Single requester:** after reset, req1 asserts a 3-beat burst with data 0x11,0x22,0x33 (`i_last` on the third), `i_ready=1`.
  - Required: `o_valid` rises one cycle after `i_req`, `o_select=1`, `o_gnt=0b0010` for 3 cycles, then IDLE, then `ptr=2`.
- **Contention:** req0 and req2 assert together from reset, each with single-beat bursts.
  - Required grant order: 0, 2, 0, 2.
  - Required: one IDLE cycle between grants and `o_gnt` never multi-hot.
- **Full rotation:** all four requesters assert continuously with 1-beat bursts.
  - Required: `o_select` sequence 0,1,2,3,0,1 on successive BUSY cycles.
- **Backpressure:** owner req3 with a 2-beat burst and `i_ready=0` for 5 cycles.
  - Required during the stall: `o_valid=1`, `o_data` stable, `o_gnt=0`, req0 pending but ignored.
  - Required after `i_ready` rises: two acknowledgements, then req0 is granted next.
- **Abort:** owner req1 drops `i_req` after 1 of 4 beats.
  - Required: return to IDLE next cycle, `ptr=2`, no `o_gnt` in the drop cycle.
- **Reset mid-burst:** assert `i_rst_n=0` during beat 2 of req2's burst.
  - Required: all outputs reach their reset values without waiting for a clock edge.
  - Required after release: the next arbitration starts from index 0.

Source files
------------

// File: rtl/rr_bus_arbiter.sv
// Burst-granular round-robin arbiter: shares one downstream port among NUM_REQ
// requesters, driving the mux select and returning per-requester beat acks.
module rr_bus_arbiter #(
  parameter  int NUM_REQ     = 4,
  parameter  int DATA_WIDTH  = 32,
  localparam int SELECT_BITS = $clog2(NUM_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ-1:0]            i_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data_bus,
  input  logic                          i_ready,
  output logic                          o_valid,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic [SELECT_BITS-1:0]        o_select,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic                          o_busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                 state_r;
  logic [SELECT_BITS-1:0] owner_r;
  logic [SELECT_BITS-1:0] ptr_r;
  logic [SELECT_BITS-1:0] win_s;
  logic [SELECT_BITS-1:0] cand_s;
  logic                   found_s;
  logic                   owner_req_s;

  // Successor index in the ring, wrapping NUM_REQ-1 back to 0 (handles non-power-of-2 NUM_REQ).
  function automatic logic [SELECT_BITS-1:0] next_idx(input logic [SELECT_BITS-1:0] idx);
    logic [SELECT_BITS-1:0] nxt;
    if (idx == SELECT_BITS'(NUM_REQ - 1)) begin
      nxt = '0;
    end else begin
      nxt = idx + SELECT_BITS'(1);
    end
    return nxt;
  endfunction

  // Scan requests starting at ptr; first set bit wins.
  always_comb begin
    win_s   = ptr_r;
    cand_s  = ptr_r;
    found_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_s && i_req[cand_s]) begin
        win_s   = cand_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
      cand_s = next_idx(cand_s);
    end
  end

  assign owner_req_s = i_req[owner_r];

  // Arbitration FSM: owner holds the port until its last beat is accepted or it aborts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      owner_r <= '0;
      ptr_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|i_req) begin
            owner_r <= win_s;
            state_r <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          // Abort (request dropped) and accepted last beat both release the port.
          if (!owner_req_s || (i_ready && i_last[owner_r])) begin
            state_r <= IDLE;
            ptr_r   <= next_idx(owner_r);
          end else begin
            state_r <= BUSY;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Datapath mux and beat acknowledge for the current owner.
  always_comb begin
    o_valid = 1'b0;
    o_data  = '0;
    o_gnt   = '0;
    if (state_r == BUSY && owner_req_s) begin
      o_valid        = 1'b1;
      o_data         = i_data_bus[int'(owner_r)*DATA_WIDTH +: DATA_WIDTH];
      o_gnt[owner_r] = i_ready;
    end else begin
      o_valid = 1'b0;
    end
  end

  assign o_select = owner_r;
  assign o_busy   = (state_r == BUSY);

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed-vector bench for rr_bus_arbiter with hand-computed expectations.
module tb_rr_bus_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;

  logic            i_clk;
  logic            i_rst_n;
  logic [NR-1:0]   i_req;
  logic [NR-1:0]   i_last;
  logic [NR*DW-1:0] i_data_bus;
  logic            i_ready;
  logic            o_valid;
  logic [DW-1:0]   o_data;
  logic [1:0]      o_select;
  logic [NR-1:0]   o_gnt;
  logic            o_busy;

  int n_checks = 0;
  int n_errors = 0;

  rr_bus_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req      (i_req),
    .i_last     (i_last),
    .i_data_bus (i_data_bus),
    .i_ready    (i_ready),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_select   (o_select),
    .o_gnt      (o_gnt),
    .o_busy     (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic set_data(input int k, input logic [31:0] v);
    i_data_bus[k*DW +: DW] = v;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_valid"},  32'(o_valid),  32'h0);
    check({tag, "_gnt"},    32'(o_gnt),    32'h0);
    check({tag, "_data"},   o_data,        32'h0);
    check({tag, "_select"}, 32'(o_select), 32'h0);
    check({tag, "_busy"},   32'(o_busy),   32'h0);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_req = '0; i_last = '0; i_ready = 1'b0; i_data_bus = '0;
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  logic [3:0] exp_gnt;

  initial begin
    i_rst_n = 1'b0;
    i_req = '0; i_last = '0; i_ready = 1'b0; i_data_bus = '0;
    tick();
    check_reset_outs("rst");
    do_reset();

    // Single requester: req1 3-beat burst.
    i_req = 4'b0010; i_ready = 1'b1; set_data(1, 32'h11); #1;
    check("t1_idle_valid", 32'(o_valid), 32'h0);
    check("t1_idle_busy",  32'(o_busy),  32'h0);
    tick();
    #1;
    check("t1_b1_valid",  32'(o_valid),  32'h1);
    check("t1_b1_select", 32'(o_select), 32'h1);
    check("t1_b1_gnt",    32'(o_gnt),    32'h2);
    check("t1_b1_data",   o_data,        32'h11);
    tick();
    set_data(1, 32'h22); #1;
    check("t1_b2_gnt",  32'(o_gnt), 32'h2);
    check("t1_b2_data", o_data,     32'h22);
    tick();
    set_data(1, 32'h33); i_last = 4'b0010; #1;
    check("t1_b3_gnt",  32'(o_gnt), 32'h2);
    check("t1_b3_data", o_data,     32'h33);
    tick();
    i_req = 4'b0110; i_last = 4'b0100; set_data(2, 32'h44); #1;
    check("t1_end_busy", 32'(o_busy),  32'h0);
    check("t1_end_gnt",  32'(o_gnt),   32'h0);
    tick();
    #1;
    check("t1_ptr2_select", 32'(o_select), 32'h2);
    check("t1_ptr2_gnt",    32'(o_gnt),    32'h4);
    tick();
    i_req = '0; i_last = '0;

    // Contention: req0 and req2 from reset, single-beat bursts.
    do_reset();
    i_req = 4'b0101; i_last = 4'b0101; i_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      exp_gnt = (g % 2 == 0) ? 4'b0001 : 4'b0100;
      #1;
      check("ct_idle_busy", 32'(o_busy), 32'h0);
      check("ct_idle_gnt",  32'(o_gnt),  32'h0);
      tick();
      #1;
      check("ct_gnt", 32'(o_gnt), 32'(exp_gnt));
      tick();
    end
    i_req = '0; i_last = '0;

    // Full rotation: all four request continuously.
    do_reset();
    for (int k = 0; k < NR; k++) set_data(k, 32'hA0 + 32'(k));
    i_req = 4'b1111; i_last = 4'b1111; i_ready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      tick();
      #1;
      check("rot_select", 32'(o_select), 32'(g % NR));
      check("rot_data",   o_data,        32'hA0 + 32'(g % NR));
      tick();
    end
    i_req = '0; i_last = '0;
    // ptr is now 2

    // Backpressure: req3 owns, 2-beat burst, ready low for 5 cycles.
    i_req = 4'b1000; i_ready = 1'b0; set_data(3, 32'hB1); set_data(0, 32'hC0);
    tick();
    i_req = 4'b1001;
    for (int s = 0; s < 5; s++) begin
      #1;
      check("bp_valid",  32'(o_valid),  32'h1);
      check("bp_data",   o_data,        32'hB1);
      check("bp_gnt",    32'(o_gnt),    32'h0);
      check("bp_select", 32'(o_select), 32'h3);
      tick();
    end
    i_ready = 1'b1; #1;
    check("bp_ack1", 32'(o_gnt), 32'h8);
    tick();
    set_data(3, 32'hB2); i_last = 4'b1000; #1;
    check("bp_ack2",  32'(o_gnt), 32'h8);
    check("bp_data2", o_data,     32'hB2);
    tick();
    i_req = 4'b0001; i_last = 4'b0001; #1;
    check("bp_bubble", 32'(o_busy), 32'h0);
    tick();
    #1;
    check("bp_next_select", 32'(o_select), 32'h0);
    check("bp_next_gnt",    32'(o_gnt),    32'h1);
    tick();
    i_req = '0; i_last = '0;
    // ptr is now 1

    // Abort: req1 drops after one of four beats.
    i_req = 4'b0010; set_data(1, 32'hD1);
    tick();
    #1;
    check("ab_b1_gnt", 32'(o_gnt), 32'h2);
    tick();
    i_req = 4'b0000; #1;
    check("ab_drop_gnt",   32'(o_gnt),   32'h0);
    check("ab_drop_valid", 32'(o_valid), 32'h0);
    tick();
    #1;
    check("ab_idle_busy", 32'(o_busy), 32'h0);
    i_req = 4'b0110; i_last = 4'b0100;
    tick();
    #1;
    check("ab_ptr2_select", 32'(o_select), 32'h2);
    tick();
    i_req = '0; i_last = '0;
    // ptr is now 3

    // Reset mid-burst of req2.
    i_req = 4'b0100; set_data(2, 32'hE1);
    tick();
    #1;
    check("rm_b1_gnt", 32'(o_gnt), 32'h4);
    tick();
    set_data(2, 32'hE2); #1;
    check("rm_b2_data", o_data, 32'hE2);
    i_rst_n = 1'b0; #1;
    check_reset_outs("rm_async");
    tick();
    i_req = 4'b1100; i_last = 4'b1100;
    i_rst_n = 1'b1;
    tick();
    #1;
    check("rm_after_select", 32'(o_select), 32'h2);
    check("rm_after_gnt",    32'(o_gnt),    32'h4);
    tick();
    i_req = '0; i_last = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
